pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register. Successor to the fixed ID/EX latch.
//  Carries NUM_OPS operands, an immediate, rs/rt/rd and a control bundle.
//  Adds valid/ready handshake, stall, flush-to-bubble and a bubble counter.
//  Sits between any two MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  DATA_W   32  operand/immediate width
//  NUM_OPS  2   number of register operands carried
//  ADDR_W   5   register-index width (rs, rt, rd)
//  CTRL_W   12  control bundle width (AluControl, AluSrc, RegWrite, MemtoReg, MemWrite, RegDst, Branch)
//  CNT_W    16  bubble counter width
// PORTS
//  clk         in   1                 rising-edge clock
//  rst         in   1                 synchronous, active-high reset
//  flush       in   1                 discard held and incoming instruction(s)
//  in_valid    in   1                 upstream holds a valid instruction
//  in_ready    out  1                 stage accepts this cycle
//  in_ops      in   NUM_OPS*DATA_W    operands; op0 in LSBs
//  in_imm      in   DATA_W            sign-extended immediate
//  in_regs     in   3*ADDR_W          {rd, rt, rs}; rs in LSBs
//  in_ctrl     in   CTRL_W            control bundle
//  out_valid   out  1                 output fields hold a valid instruction
//  out_ready   in   1                 downstream accepts (0 = stall)
//  out_ops     out  NUM_OPS*DATA_W    registered operands
//  out_imm     out  DATA_W            registered immediate
//  out_regs    out  3*ADDR_W          registered indices
//  out_ctrl    out  CTRL_W            registered control; all-zero when out_valid=0
//  bubble_cnt  out  CNT_W             cycles a bubble was presented with out_ready=1
// BEHAVIOUR
//  - One clock, clk. rst is synchronous and active-high.
//  - Reset: out_valid=0; out_ops, out_imm, out_regs, out_ctrl and bubble_cnt = 0; stage EMPTY.
//  - Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
//  - Latency: an instruction accepted in cycle N appears on out_* in cycle N+1.
//  - Stall: while out_valid & ~out_ready, all out_* hold their values.
//  - Priority: rst > flush > normal operation.
//  - Flush (in effect the cycle after flush=1):
//    - out_valid=0, out_ctrl=0, skid entry cleared.
//    - Any instruction accepted in the flush cycle is dropped.
//    - out_ops, out_imm and out_regs hold their values.
//  - Flush and stall together: flush wins and the bubble replaces the stalled instruction.
//  - Bubble invariant: out_valid=0 implies out_ctrl=0, so RegWrite and MemWrite never assert on a bubble.
//  - bubble_cnt: +1 on each cycle with ~out_valid & out_ready. Saturates at 2^CNT_W-1. Cleared only by rst.
//  - Without skid, states are EMPTY and FULL:
//    - in_ready = out_ready | ~out_valid (combinational).
//    - EMPTY->FULL on accept. FULL->EMPTY on deliver without accept. FULL->FULL on deliver with accept, or on stall.
// CONFIGURATION
//  - Macro PIPE_STAGE_SKID_EN adds a one-entry skid buffer, giving states EMPTY, FULL and SKID.
//  - In that mode in_ready is registered: in_ready = (state != SKID), with no combinational path from out_ready.
//  - FULL & accept & ~out_ready -> SKID; the new instruction goes to the skid entry.
//  - SKID & out_ready -> FULL; the skid entry moves to out_*. in_ready returns to 1 the next cycle.
//  - Without the macro, the two-state combinational-ready behaviour above applies.
//  - Throughput is 1 instruction per cycle in both modes.
// STRUCTURE
//  - Shared package mips_pipe_pkg:
//    - state encoding: ST_EMPTY, ST_FULL, ST_SKID;
//    - CTRL field offsets: ALU_CTRL_LSB, ALUSRC_BIT, REGWRITE_BIT, MEMTOREG_BIT, MEMWRITE_BIT, REGDST_BIT, BRANCH_BIT;
//    - default widths.
//  - Sub-module pipe_payload_reg: a single DATA/ADDR/CTRL payload register with load enable and ctrl clear.
//    Instantiated once for the main entry, plus once more for the skid entry when PIPE_STAGE_SKID_EN is defined.
// TESTING
//  1. Reset:
//     rst=1 for 2 cycles with in_valid=1 and in_ctrl=12'hFFF -> out_valid=0, out_ctrl=0, bubble_cnt=0.
//  2. Streaming:
//     in_ops={32'h2,32'h1}, in_imm=32'hFFFF_FFFC, one instruction per cycle, out_ready=1 ->
//     out_* matches in_* one cycle later, back-to-back with no gaps.
//  3. Stall:
//     FULL holding ctrl=12'h0A5, out_ready=0 for 3 cycles ->
//     out_* constant for 3 cycles; in_ready=0 (skid mode: 1 for one cycle, then 0);
//     no loss or duplication when out_ready returns to 1.
//  4. Flush during stall:
//     out_valid=1, out_ready=0, flush=1, in_valid=1 ->
//     next cycle out_valid=0, out_ctrl=0, and the incoming instruction is never delivered.
//  5. Bubble counter:
//     CNT_W=4, in_valid=0, out_ready=1 for 20 cycles -> bubble_cnt reaches 15 and holds at 15.
//  6. Skid ordering (PIPE_STAGE_SKID_EN):
//     accept A, B, C while out_ready toggles 0/1 each cycle -> delivered in order A, B, C, exactly once each.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pipe_pkg;

    // Default widths for a 32-bit MIPS datapath
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_OPS = 2;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_CTRL_W  = 12;
    localparam int DEF_CNT_W   = 16;

    // Control bundle layout: AluControl occupies the low bits, single-bit flags above it
    localparam int ALU_CTRL_LSB = 0;
    localparam int ALU_CTRL_W   = 6;
    localparam int ALUSRC_BIT   = 6;
    localparam int REGWRITE_BIT = 7;
    localparam int MEMTOREG_BIT = 8;
    localparam int MEMWRITE_BIT = 9;
    localparam int REGDST_BIT   = 10;
    localparam int BRANCH_BIT   = 11;

    // Stage occupancy; ST_SKID only reachable when the skid entry is built
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// One instruction payload register (operands, immediate, indices, control).
// Latency: 1 cycle from load to output.
// Backpressure: none; holds while load=0, clrCtrl zeroes only the control field.
module pipe_payload_reg #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int ADDR_W  = 5,
    parameter int CTRL_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      clrCtrl,
    input  logic [NUM_OPS*DATA_W-1:0] opsD,
    input  logic [DATA_W-1:0]         immD,
    input  logic [3*ADDR_W-1:0]       regsD,
    input  logic [CTRL_W-1:0]         ctrlD,
    output logic [NUM_OPS*DATA_W-1:0] opsQ,
    output logic [DATA_W-1:0]         immQ,
    output logic [3*ADDR_W-1:0]       regsQ,
    output logic [CTRL_W-1:0]         ctrlQ
);

    // Load the whole payload, or just zero the control so a bubble never writes
    always_ff @(posedge clk) begin
        if (rst) begin
            opsQ  <= '0;
            immQ  <= '0;
            regsQ <= '0;
            ctrlQ <= '0;
        end else if (load) begin
            opsQ  <= opsD;
            immQ  <= immD;
            regsQ <= regsD;
            ctrlQ <= ctrlD;
        end else if (clrCtrl) begin
            ctrlQ <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised MIPS inter-stage register with valid/ready, flush-to-bubble and bubble counter.
// Latency: 1 cycle accept-to-output; optional skid entry via macro PIPE_STAGE_SKID_EN.
// Backpressure: holds outputs while out_ready=0; in_ready combinational, or registered with skid.
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [3*ADDR_W-1:0]       in_regs,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [DATA_W-1:0]         out_imm,
    output logic [3*ADDR_W-1:0]       out_regs,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [CNT_W-1:0]          bubble_cnt
);

    stage_state_e state;
    stage_state_e stateNext;

    logic accept;
    logic mainLoad;
    logic mainClr;

    logic [NUM_OPS*DATA_W-1:0] mainOps;
    logic [DATA_W-1:0]         mainImm;
    logic [3*ADDR_W-1:0]       mainRegs;
    logic [CTRL_W-1:0]         mainCtrl;

    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic mainFromSkid;
    logic skidLoad;

    logic [NUM_OPS*DATA_W-1:0] skidOps;
    logic [DATA_W-1:0]         skidImm;
    logic [3*ADDR_W-1:0]       skidRegs;
    logic [CTRL_W-1:0]         skidCtrl;

    // Ready comes straight from the state register, so out_ready never reaches in_ready
    assign in_ready = (state != ST_SKID);

    // The main entry refills from the skid entry when draining, otherwise from upstream
    assign mainOps  = mainFromSkid ? skidOps  : in_ops;
    assign mainImm  = mainFromSkid ? skidImm  : in_imm;
    assign mainRegs = mainFromSkid ? skidRegs : in_regs;
    assign mainCtrl = mainFromSkid ? skidCtrl : in_ctrl;

    pipe_payload_reg #(
        .DATA_W  (DATA_W),
        .NUM_OPS (NUM_OPS),
        .ADDR_W  (ADDR_W),
        .CTRL_W  (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skidLoad),
        .clrCtrl (flush),
        .opsD    (in_ops),
        .immD    (in_imm),
        .regsD   (in_regs),
        .ctrlD   (in_ctrl),
        .opsQ    (skidOps),
        .immQ    (skidImm),
        .regsQ   (skidRegs),
        .ctrlQ   (skidCtrl)
    );

    // Next state and entry load controls; flush overrides every transition
    always_comb begin
        stateNext    = state;
        mainLoad     = 1'b0;
        mainClr      = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        if (flush) begin
            stateNext = ST_EMPTY;
            mainClr   = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        mainLoad  = 1'b1;
                        stateNext = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && out_ready) begin
                        mainLoad = 1'b1;
                    end else if (accept) begin
                        skidLoad  = 1'b1;
                        stateNext = ST_SKID;
                    end else if (out_ready) begin
                        mainClr   = 1'b1;
                        stateNext = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        mainLoad     = 1'b1;
                        mainFromSkid = 1'b1;
                        stateNext    = ST_FULL;
                    end
                end
                default: begin
                    mainClr   = 1'b1;
                    stateNext = ST_EMPTY;
                end
            endcase
        end
    end
`else
    // A held instruction can be replaced in the same cycle it leaves
    assign in_ready = out_ready | ~out_valid;

    assign mainOps  = in_ops;
    assign mainImm  = in_imm;
    assign mainRegs = in_regs;
    assign mainCtrl = in_ctrl;

    // Next state and main entry controls; flush overrides every transition
    always_comb begin
        stateNext = state;
        mainLoad  = 1'b0;
        mainClr   = 1'b0;
        if (flush) begin
            stateNext = ST_EMPTY;
            mainClr   = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        mainLoad  = 1'b1;
                        stateNext = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        mainLoad = 1'b1;
                    end else if (out_ready) begin
                        mainClr   = 1'b1;
                        stateNext = ST_EMPTY;
                    end
                end
                default: begin
                    mainClr   = 1'b1;
                    stateNext = ST_EMPTY;
                end
            endcase
        end
    end
`endif

    pipe_payload_reg #(
        .DATA_W  (DATA_W),
        .NUM_OPS (NUM_OPS),
        .ADDR_W  (ADDR_W),
        .CTRL_W  (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (mainLoad),
        .clrCtrl (mainClr),
        .opsD    (mainOps),
        .immD    (mainImm),
        .regsD   (mainRegs),
        .ctrlD   (mainCtrl),
        .opsQ    (out_ops),
        .immQ    (out_imm),
        .regsQ   (out_regs),
        .ctrlQ   (out_ctrl)
    );

    // Occupancy register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Count cycles where downstream was ready but only got a bubble; saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && out_ready && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
